// File: rtl/i2s_rx_if.sv
// Bundle of the I2S capture pins and the host-side FIFO read port of i2s_rx.
interface i2s_rx_if #(
  parameter int DATA_WIDTH      = 24,
  parameter int FIFO_DEPTH_LOG2 = 2
);
  logic                       i2s_lrck;
  logic                       i2s_bck;
  logic                       i2s_data;
  logic                       rd_en;
  logic [DATA_WIDTH-1:0]      rd_left;
  logic [DATA_WIDTH-1:0]      rd_right;
  logic                       rd_valid;
  logic [FIFO_DEPTH_LOG2:0]   fifo_count;

  modport slave (
    input  i2s_lrck, i2s_bck, i2s_data, rd_en,
    output rd_left, rd_right, rd_valid, fifo_count
  );

  modport master (
    output i2s_lrck, i2s_bck, i2s_data, rd_en,
    input  rd_left, rd_right, rd_valid, fifo_count
  );
endinterface

// File: rtl/i2s_rx.sv
// I2S slave receiver: synchronizes LRCK/BCK/DATA, frames left/right words
// MSB-first and queues stereo pairs in a show-ahead FIFO for the host.
module i2s_rx #(
  parameter int DATA_WIDTH      = 24,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     enable,
  input  logic     clr_flags,
  i2s_rx_if.slave  bus,
  output logic     overrun,
  output logic     frame_err
);
  localparam int CW    = $clog2(DATA_WIDTH) + 2;
  localparam int AW    = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, WAIT_LEFT, LEFT_HELD} state_t;

  logic [1:0]            r_lrckSync, r_bckSync, r_dataSync;
  logic                  r_bckPrev;
  logic                  w_bckRise, w_lr, w_d;

  logic                  r_lrPrev;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_shift, r_leftWord, w_newWord;
  state_t                r_state, w_nextState;
  logic                  w_close, w_shortSlot, w_leftCapture, w_push, w_frameErrSet;

  logic [DATA_WIDTH-1:0] r_memLeft  [DEPTH];
  logic [DATA_WIDTH-1:0] r_memRight [DEPTH];
  logic [AW-1:0]         r_wrPtr, r_rdPtr, w_nextRdPtr;
  logic [AW:0]           r_count, w_nextCount;
  logic                  w_pop, w_full, w_write, w_overrunSet;
  logic [DATA_WIDTH-1:0] r_rdLeft, r_rdRight, w_headLeft, w_headRight;
  logic                  r_overrun, r_frameErr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lrckSync <= '0;
      r_bckSync  <= '0;
      r_dataSync <= '0;
      r_bckPrev  <= 1'b0;
    end else begin
      r_lrckSync <= {r_lrckSync[0], bus.i2s_lrck};
      r_bckSync  <= {r_bckSync[0], bus.i2s_bck};
      r_dataSync <= {r_dataSync[0], bus.i2s_data};
      r_bckPrev  <= r_bckSync[1];
    end
  end

  assign w_bckRise   = r_bckSync[1] & ~r_bckPrev;
  assign w_lr        = r_lrckSync[1];
  assign w_d         = r_dataSync[1];
  assign w_close     = enable && w_bckRise && (w_lr != r_lrPrev);
  assign w_shortSlot = r_cnt < CW'(DATA_WIDTH - 1);

  // Bits past DATA_WIDTH match no position, which truncates long slots.
  always_comb begin
    w_newWord = r_shift;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (r_cnt == CW'(DATA_WIDTH - 1 - i)) w_newWord[i] = w_d;
    end
  end

  always_comb begin
    w_nextState   = r_state;
    w_push        = 1'b0;
    w_leftCapture = 1'b0;
    w_frameErrSet = 1'b0;
    if (!enable) begin
      w_nextState = IDLE;
    end else if (w_close) begin
      case (r_state)
        IDLE: w_nextState = WAIT_LEFT;
        WAIT_LEFT: begin
          w_frameErrSet = w_shortSlot;
          if (!r_lrPrev) begin
            w_leftCapture = 1'b1;
            w_nextState   = LEFT_HELD;
          end
        end
        LEFT_HELD: begin
          w_frameErrSet = w_shortSlot;
          if (!r_lrPrev) begin
            w_leftCapture = 1'b1;
          end else begin
            w_push      = 1'b1;
            w_nextState = WAIT_LEFT;
          end
        end
        default: w_nextState = IDLE;
      endcase
    end
  end

  // lr_prev keeps tracking LRCK while disabled so re-enabling mid-slot
  // does not fake a transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_lrPrev   <= 1'b0;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_leftWord <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_bckRise) r_lrPrev <= w_lr;
      if (!enable) begin
        r_cnt   <= '0;
        r_shift <= '0;
      end else if (w_bckRise) begin
        if (w_lr != r_lrPrev) begin
          r_cnt   <= '0;
          r_shift <= '0;
        end else begin
          r_shift <= w_newWord;
          if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
        end
      end
      if (w_leftCapture) r_leftWord <= w_newWord;
    end
  end

  assign w_pop        = bus.rd_en && (r_count != '0);
  assign w_full       = r_count == (AW + 1)'(DEPTH);
  assign w_write      = w_push && (!w_full || w_pop);
  assign w_overrunSet = w_push && w_full && !w_pop;
  assign w_nextRdPtr  = w_pop ? r_rdPtr + 1'b1 : r_rdPtr;
  assign w_nextCount  = r_count + (AW + 1)'(w_write) - (AW + 1)'(w_pop);

  // Head for next cycle, bypassing the entry being written when it lands at the head.
  always_comb begin
    w_headLeft  = r_memLeft[w_nextRdPtr];
    w_headRight = r_memRight[w_nextRdPtr];
    if (w_write && (r_wrPtr == w_nextRdPtr)) begin
      w_headLeft  = r_leftWord;
      w_headRight = w_newWord;
    end
    if (w_nextCount == '0) begin
      w_headLeft  = '0;
      w_headRight = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_write) begin
      r_memLeft[r_wrPtr]  <= r_leftWord;
      r_memRight[r_wrPtr] <= w_newWord;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_rdLeft   <= '0;
      r_rdRight  <= '0;
      r_overrun  <= 1'b0;
      r_frameErr <= 1'b0;
    end else begin
      if (w_write) r_wrPtr <= r_wrPtr + 1'b1;
      r_rdPtr    <= w_nextRdPtr;
      r_count    <= w_nextCount;
      r_rdLeft   <= w_headLeft;
      r_rdRight  <= w_headRight;
      r_overrun  <= w_overrunSet | (r_overrun & ~clr_flags);
      r_frameErr <= w_frameErrSet | (r_frameErr & ~clr_flags);
    end
  end

  assign bus.rd_left    = r_rdLeft;
  assign bus.rd_right   = r_rdRight;
  assign bus.rd_valid   = r_count != '0;
  assign bus.fifo_count = r_count;
  assign overrun        = r_overrun;
  assign frame_err      = r_frameErr;
endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: drives I2S frames at BCK = clk/8 and compares
// the FIFO read port and flags against a queue-based model of received pairs.
module tb_i2s_rx;
  logic clk = 1'b0;
  logic rst, enable, clrFlags;
  logic overrun, frameErr;

  i2s_rx_if busIf ();

  i2s_rx dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .clr_flags (clrFlags),
    .bus       (busIf),
    .overrun   (overrun),
    .frame_err (frameErr)
  );

  always #5 clk = ~clk;

  logic [1:0]  edgeQ [$];
  logic [47:0] modelQ [$];
  bit          modelOverrun, modelFrameErr;
  int          errors = 0;
  int          checks = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkHead(input string tag);
    checkOutput({tag, ".count"}, 32'(busIf.fifo_count), 32'(modelQ.size()));
    checkOutput({tag, ".valid"}, 32'(busIf.rd_valid), 32'(modelQ.size() != 0));
    if (modelQ.size() != 0) begin
      checkOutput({tag, ".left"},  32'(busIf.rd_left),  32'(modelQ[0][47:24]));
      checkOutput({tag, ".right"}, 32'(busIf.rd_right), 32'(modelQ[0][23:0]));
    end
  endtask

  task automatic checkFlags(input string tag);
    checkOutput({tag, ".overrun"},   32'(overrun),  32'(modelOverrun));
    checkOutput({tag, ".frame_err"}, 32'(frameErr), 32'(modelFrameErr));
  endtask

  // One BCK period: data/LRCK change while BCK is low, sampled on the rise.
  task automatic applyStimulus(input logic lr, input logic d);
    busIf.i2s_bck  = 1'b0;
    busIf.i2s_lrck = lr;
    busIf.i2s_data = d;
    repeat (4) @(negedge clk);
    busIf.i2s_bck = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Same as applyStimulus but pulses rd_en in the cycle the resulting push lands.
  task automatic applyStimulusWithPop(input logic lr, input logic d);
    busIf.i2s_bck  = 1'b0;
    busIf.i2s_lrck = lr;
    busIf.i2s_data = d;
    repeat (4) @(negedge clk);
    busIf.i2s_bck = 1'b1;
    repeat (2) @(negedge clk);
    busIf.rd_en = 1'b1;
    @(negedge clk);
    busIf.rd_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic playEdges(input int n);
    logic [1:0] e;
    for (int i = 0; i < n; i++) begin
      e = edgeQ.pop_front();
      applyStimulus(e[1], e[0]);
    end
  endtask

  task automatic playAll();
    playEdges(edgeQ.size());
  endtask

  // A slot of len bits whose final bit rides on the edge where LRCK has flipped.
  task automatic pushSlot(input logic chan, input logic [23:0] payload, input int len);
    logic [31:0] s;
    if (len >= 24) s = ({8'h0, payload} << (len - 24)) | ($urandom & ((32'h1 << (len - 24)) - 1));
    else           s = {8'h0, payload} >> (24 - len);
    for (int k = 0; k < len; k++) edgeQ.push_back({(k == len - 1) ? ~chan : chan, s[len - 1 - k]});
  endtask

  function automatic logic [23:0] expWord(input logic [23:0] payload, input int len);
    if (len >= 24) return payload;
    return (payload >> (24 - len)) << (24 - len);
  endfunction

  task automatic modelPush(input logic [23:0] l, input logic [23:0] r);
    if (modelQ.size() < 4) modelQ.push_back({l, r});
    else modelOverrun = 1'b1;
  endtask

  task automatic sendPair(input logic [23:0] l, input logic [23:0] r, input int len);
    pushSlot(1'b0, l, len);
    pushSlot(1'b1, r, len);
    playAll();
    modelPush(expWord(l, len), expWord(r, len));
    if (len < 24) modelFrameErr = 1'b1;
  endtask

  task automatic popOne(input string tag);
    busIf.rd_en = 1'b1;
    @(negedge clk);
    busIf.rd_en = 1'b0;
    if (modelQ.size() != 0) void'(modelQ.pop_front());
    checkHead(tag);
  endtask

  task automatic pulseClear();
    clrFlags = 1'b1;
    @(negedge clk);
    clrFlags = 1'b0;
    modelOverrun  = 1'b0;
    modelFrameErr = 1'b0;
  endtask

  function automatic logic [23:0] rnd24();
    return 24'($urandom);
  endfunction

  initial begin
    logic [23:0] l, r;
    logic [1:0]  e;
    rst = 1'b1; enable = 1'b1; clrFlags = 1'b0;
    busIf.rd_en = 1'b0; busIf.i2s_bck = 1'b0; busIf.i2s_lrck = 1'b0; busIf.i2s_data = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkHead("reset");
    checkOutput("reset.left", 32'(busIf.rd_left), 32'h0);
    checkFlags("reset");

    $display("[TB] 32-bit slots, first pair after sync");
    pushSlot(1'b1, rnd24(), 32);
    playAll();
    sendPair(24'h123456, 24'hABCDEF, 32);
    checkHead("slot32");
    checkFlags("slot32");
    popOne("slot32.pop");

    $display("[TB] 24-bit and 16-bit slots");
    sendPair(24'h800000, 24'h7FFFFF, 24);
    checkHead("slot24");
    checkFlags("slot24");
    popOne("slot24.pop");
    sendPair(24'hBEEF00, rnd24(), 16);
    checkHead("slot16");
    checkOutput("slot16.leftval", 32'(busIf.rd_left), 32'hBEEF00);
    checkFlags("slot16");
    popOne("slot16.pop");
    pulseClear();
    checkFlags("slot16.clr");

    $display("[TB] overrun with six pairs and no reads");
    for (int i = 0; i < 6; i++) sendPair(rnd24(), rnd24(), int'($urandom_range(24, 32)));
    checkHead("full");
    checkFlags("full");
    for (int i = 0; i < 4; i++) popOne("full.drain");
    pulseClear();
    checkFlags("full.clr");

    $display("[TB] push and pop in the same cycle while full");
    for (int i = 0; i < 4; i++) sendPair(rnd24(), rnd24(), 32);
    l = rnd24(); r = rnd24();
    pushSlot(1'b0, l, 32);
    pushSlot(1'b1, r, 32);
    playEdges(edgeQ.size() - 1);
    e = edgeQ.pop_front();
    applyStimulusWithPop(e[1], e[0]);
    void'(modelQ.pop_front());
    modelPush(l, r);
    checkHead("fullpp");
    checkFlags("fullpp");
    for (int i = 0; i < 4; i++) popOne("fullpp.drain");

    $display("[TB] enable dropped mid-left, raised mid-right");
    pushSlot(1'b0, rnd24(), 32);
    pushSlot(1'b1, rnd24(), 32);
    playEdges(10);
    enable = 1'b0;
    playEdges(32);
    enable = 1'b1;
    playAll();
    checkHead("enable.resync");
    checkFlags("enable.resync");
    sendPair(rnd24(), rnd24(), 32);
    checkHead("enable.pair");
    popOne("enable.pop");

    $display("[TB] reset mid-right-slot with two entries queued");
    sendPair(rnd24(), rnd24(), 32);
    sendPair(rnd24(), rnd24(), 32);
    checkHead("rst.pre");
    pushSlot(1'b0, rnd24(), 32);
    pushSlot(1'b1, rnd24(), 32);
    playEdges(42);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    modelQ.delete();
    modelOverrun = 1'b0;
    modelFrameErr = 1'b0;
    checkHead("rst.post");
    checkFlags("rst.post");
    playAll();
    sendPair(rnd24(), rnd24(), 32);
    checkHead("rst.pair");
    checkOutput("rst.overrun", 32'(overrun), 32'h0);
    popOne("rst.pop");

    $display("[TB] read while empty");
    popOne("empty.pop");
    popOne("empty.pop2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
